bcd_to_bin_seq: RTL and testbench

//  Sequential BCD-to-binary converter: accepts NUM_DIGITS packed BCD digits over a
//  val/rdy handshake, returns the binary value over a second val/rdy handshake.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_mac_step.sv | 22 ++
 rtl/bcd_to_bin_seq.sv | 110 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential BCD-to-binary converter.
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BCD_MAX = 9;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

endpackage

// File: rtl/bcd_mac_step.sv
// One multiply-accumulate step: result = acc*10 + digit, truncated to BIN_W bits.
module bcd_mac_step
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W = 7
) (
   input  logic [BIN_W-1:0]   acc,
   input  logic [DIGIT_W-1:0] digit,
   output logic [BIN_W-1:0]   result
);

   logic [BIN_W+DIGIT_W-1:0] acc_ext;
   logic [BIN_W+DIGIT_W-1:0] digit_ext;
   logic [BIN_W+DIGIT_W-1:0] sum;

   // Widened so the x10 never wraps before the final truncation.
   assign acc_ext   = {{DIGIT_W{1'b0}}, acc};
   assign digit_ext = {{BIN_W{1'b0}}, digit};
   assign sum       = (acc_ext << 3) + (acc_ext << 1) + digit_ext;
   assign result    = sum[BIN_W-1:0];

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, MSD first, one digit per cycle.
// Define BCD2BIN_DIGIT_CHECK_EN to flag input digits above 9 on out_err.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 2,
   parameter int unsigned BIN_W      = 7
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_val,
   output logic                          in_rdy,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] in_bcd,
   output logic                          out_val,
   input  logic                          out_rdy,
   output logic [BIN_W-1:0]              out_bin,
   output logic                          out_err
);

   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   state_e                          state_q, state_d;
   logic [BIN_W-1:0]                acc_q, acc_d, acc_step;
   logic [IdxW-1:0]                 idx_q, idx_d;
   logic [DIGIT_W*NUM_DIGITS-1:0]   dig_q, dig_d;
   logic [DIGIT_W-1:0]              cur_digit;

   assign cur_digit = dig_q[idx_q*DIGIT_W +: DIGIT_W];

   bcd_mac_step #(
      .BIN_W (BIN_W)
   ) u_mac (
      .acc    (acc_q),
      .digit  (cur_digit),
      .result (acc_step)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      dig_d   = dig_q;
      in_rdy  = 1'b0;
      out_val = 1'b0;
      case (state_q)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_val) begin
               dig_d   = in_bcd;
               acc_d   = '0;
               idx_d   = IdxW'(NUM_DIGITS - 1);
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = acc_step;
            if (idx_q == '0) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         DONE: begin
            out_val = 1'b1;
            if (out_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         dig_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         dig_q   <= dig_d;
      end
   end

   // Gated so out_bin reads zero outside DONE, matching its reset value.
   assign out_bin = out_val ? acc_q : '0;

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == IDLE && in_val) begin
         err_d = 1'b0;
      end else if (state_q == CALC) begin
         err_d = err_q | (cur_digit > DIGIT_W'(BCD_MAX));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign out_err = out_val & err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq (2-digit and 3-digit instances).
module tb_bcd_to_bin_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_val = 1'b0, in_rdy, out_val, out_rdy = 1'b0, out_err;
   logic [7:0]  in_bcd = '0;
   logic [6:0]  out_bin;

   logic        in_val3 = 1'b0, in_rdy3, out_val3, out_rdy3 = 1'b0, out_err3;
   logic [11:0] in_bcd3 = '0;
   logic [9:0]  out_bin3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd_to_bin_seq #(
      .NUM_DIGITS (2),
      .BIN_W      (7)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in_bcd  (in_bcd),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out_bin (out_bin),
      .out_err (out_err)
   );

   bcd_to_bin_seq #(
      .NUM_DIGITS (3),
      .BIN_W      (10)
   ) u_dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_val  (in_val3),
      .in_rdy  (in_rdy3),
      .in_bcd  (in_bcd3),
      .out_val (out_val3),
      .out_rdy (out_rdy3),
      .out_bin (out_bin3),
      .out_err (out_err3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: sum of d_i * 10^i modulo 2^bw, digits taken at face value.
   function automatic int unsigned ref_val(input logic [11:0] bcd, input int nd, input int bw);
      int unsigned sum = 0;
      int unsigned pw = 1;
      logic [11:0] b = bcd;
      for (int i = 0; i < nd; i++) begin
         sum += 32'(b[4*i +: 4]) * pw;
         pw *= 10;
      end
      return sum % (32'd1 << bw);
   endfunction

   function automatic logic ref_err(input logic [11:0] bcd, input int nd);
      logic e = 1'b0;
      logic [11:0] b = bcd;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      for (int i = 0; i < nd; i++) if (b[4*i +: 4] > 4'd9) e = 1'b1;
`else
      e = (nd < 0) ? b[0] : 1'b0;
`endif
      return e;
   endfunction

   task automatic convert(input logic [7:0] bcd, input int hold);
      int cyc = 0;
      logic [6:0] exp_bin = 7'(ref_val({4'h0, bcd}, 2, 7));
      logic       exp_err = ref_err({4'h0, bcd}, 2);
      check("in_rdy_idle", in_rdy, 1);
      in_bcd = bcd;
      in_val = 1'b1;
      out_rdy = 1'b0;
      @(posedge clk); #1;
      in_val = 1'b0;
      in_bcd = 8'($urandom);
      while (!out_val && cyc < 20) begin
         if (in_rdy) check("in_rdy_calc", in_rdy, 0);
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, 2);
      check("out_bin", out_bin, exp_bin);
      check("out_err", out_err, exp_err);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_val", out_val, 1);
         check("hold_bin", out_bin, exp_bin);
         check("hold_rdy", in_rdy, 0);
      end
      out_rdy = 1'b1;
      @(posedge clk); #1;
      out_rdy = 1'b0;
      check("post_val", out_val, 0);
      check("post_rdy", in_rdy, 1);
   endtask

   task automatic convert3(input logic [11:0] bcd);
      int cyc = 0;
      in_bcd3 = bcd;
      in_val3 = 1'b1;
      out_rdy3 = 1'b1;
      @(posedge clk); #1;
      in_val3 = 1'b0;
      while (!out_val3 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency3", cyc, 3);
      check("out_bin3", out_bin3, ref_val(bcd, 3, 10));
      check("out_err3", out_err3, ref_err(bcd, 3));
      @(posedge clk); #1;
      check("post_val3", out_val3, 0);
      out_rdy3 = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_in_rdy", in_rdy, 1);
      check("rst_out_val", out_val, 0);
      check("rst_out_bin", out_bin, 0);
      check("rst_out_err", out_err, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      convert(8'h42, 0);
      convert(8'h00, 0);
      convert(8'h99, 0);
      convert(8'h31, 0);
      convert(8'h37, 5);
      convert(8'h1A, 1);

      // Abort mid-CALC; the stale transaction must never surface.
      in_bcd = 8'h58;
      in_val = 1'b1;
      @(posedge clk); #1;
      in_val = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("abort_out_val", out_val, 0);
      check("abort_in_rdy", in_rdy, 1);
      check("abort_out_bin", out_bin, 0);
      check("abort_out_err", out_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("no_stale_val", out_val, 0);
      convert(8'h12, 0);

      for (int n = 0; n < 30; n++) begin
         logic [7:0] b = 8'($urandom);
         if (n % 3 != 0) b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         convert(b, int'($urandom_range(0, 3)));
      end

      convert3(12'h999);
      convert3(12'h000);
      convert3(12'h9F9);
      for (int n = 0; n < 10; n++) convert3(12'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
